// File: rtl/hazard_stall_ctrl_if.sv
// Purpose: bundles the ID/EX hazard inputs, AXI busy flags and pipeline control outputs of hazard_stall_ctrl.
// Latency: none; this is a bundle of wires.
// Backpressure: carried by im_busy/dm_busy, which freeze the whole pipeline.
interface hazard_stall_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              im_busy;
    logic              dm_busy;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_en;
    logic              id_ex_flush;
    logic              late_en;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Pipeline side: supplies hazard info, consumes enables/flushes.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, im_busy, dm_busy,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, late_en,
               state_o, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, im_busy, dm_busy,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, late_en,
               state_o, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Purpose: pipeline enable/flush control for load-use bubbles, branch flushes and AXI-wait freezes.
// Latency: enables/flushes are combinational (same cycle); state and perf counters update on the next clk edge.
// Backpressure: any AXI busy freezes every pipeline register; a redirect seen while frozen is replayed on release.
module hazard_stall_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MWAIT  = 2'd1,
        ST_FLUSHP = 2'd2
    } state_t;

    // Field order is the bit order of the constants below.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic late_en;
    } ctl_t;

    localparam ctl_t CTL_FRZ  = 6'b000000;
    localparam ctl_t CTL_NORM = 6'b110101;
    localparam ctl_t CTL_BR   = 6'b111111;
    localparam ctl_t CTL_LU   = 6'b000111;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q;
    state_t            state_nxt;
    ctl_t              run_ctl;
    ctl_t              ctl;
    logic              mem_busy;
    logic              load_use;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    assign rs1      = bus.id_rs1;
    assign rs2      = bus.id_rs2;
    assign rd       = bus.ex_rd;
    assign mem_busy = bus.im_busy | bus.dm_busy;
    // x0 is never a real producer, so a load to it cannot create a hazard.
    assign load_use = bus.ex_mem_read & (rd != '0) &
                      ((bus.id_use_rs1 & (rs1 == rd)) | (bus.id_use_rs2 & (rs2 == rd)));

    // Unfrozen priority: branch flush beats load-use bubble beats normal flow.
    always_comb begin
        run_ctl = CTL_NORM;
        if (bus.ex_branch_taken) begin
            run_ctl = CTL_BR;
        end else if (load_use) begin
            run_ctl = CTL_LU;
        end
    end

    // Next state and pipeline controls; freeze is the default action.
    always_comb begin
        ctl       = CTL_FRZ;
        state_nxt = state_q;
        if (rst) begin
            state_nxt = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_busy) begin
                        state_nxt = bus.ex_branch_taken ? ST_FLUSHP : ST_MWAIT;
                    end else begin
                        ctl = run_ctl;
                    end
                end
                ST_MWAIT: begin
                    if (mem_busy) begin
                        if (bus.ex_branch_taken) begin
                            state_nxt = ST_FLUSHP;
                        end
                    end else begin
                        ctl       = run_ctl;
                        state_nxt = ST_RUN;
                    end
                end
                ST_FLUSHP: begin
                    // The remembered redirect is replayed, whatever EX shows now.
                    if (!mem_busy) begin
                        ctl       = CTL_BR;
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    if (!mem_busy) begin
                        ctl = run_ctl;
                    end
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State register; reset drops any pending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Performance counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctl.pc_en) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (ctl.if_id_flush) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end

    assign bus.pc_en       = ctl.pc_en;
    assign bus.if_id_en    = ctl.if_id_en;
    assign bus.if_id_flush = ctl.if_id_flush;
    assign bus.id_ex_en    = ctl.id_ex_en;
    assign bus.id_ex_flush = ctl.id_ex_flush;
    assign bus.late_en     = ctl.late_en;
    assign bus.state_o     = state_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Purpose: directed checks of hazard_stall_ctrl bubbles, flushes, freezes, pending redirect and counter wrap.
// Latency: outputs sampled 2 ns after each negedge, before the following posedge.
// Backpressure: im_busy/dm_busy driven directly by the stimulus.
module tb_hazard_stall_ctrl;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    // Expected control words: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, late_en}
    localparam logic [5:0] O_FRZ  = 6'b000000;
    localparam logic [5:0] O_NORM = 6'b110101;
    localparam logic [5:0] O_BR   = 6'b111111;
    localparam logic [5:0] O_LU   = 6'b000111;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic [5:0] exp_o;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t tbl [10];

    hazard_stall_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_o(input string name, input logic [5:0] exp_o, input logic [1:0] exp_st);
        logic [7:0] act;
        act = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
               bus.id_ex_flush, bus.late_en, bus.state_o};
        check(name, 32'(act), 32'({exp_o, exp_st}));
    endtask

    task automatic chk_cnt(input string name, input int exp_stall, input int exp_flush);
        check({name, ".stall"}, 32'(bus.stall_cnt), 32'(exp_stall));
        check({name, ".flush"}, 32'(bus.flush_cnt), 32'(exp_flush));
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic br, input logic im, input logic dm);
        bus.id_rs1          = rs1;
        bus.id_rs2          = rs2;
        bus.id_use_rs1      = u1;
        bus.id_use_rs2      = u2;
        bus.ex_rd           = rd;
        bus.ex_mem_read     = mr;
        bus.ex_branch_taken = br;
        bus.im_busy         = im;
        bus.dm_busy         = dm;
    endtask

    // One cycle with no load-use in flight; leaves time 2 ns after the negedge.
    task automatic step(input logic br, input logic im, input logic dm);
        @(negedge clk);
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, br, im, dm);
        #2;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        //             rs1    rs2    u1    u2    rd     mr    br    expected
        tbl[0] = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd3,  1'b1, 1'b0, O_NORM}; // load, no match
        tbl[1] = '{5'd7,  5'd5,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, O_LU};   // rs2 load-use
        tbl[2] = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, O_NORM}; // rd = x0
        tbl[3] = '{5'd9,  5'd4,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, O_LU};   // rs1 load-use
        tbl[4] = '{5'd9,  5'd9,  1'b0, 1'b0, 5'd9,  1'b1, 1'b0, O_NORM}; // match, unused
        tbl[5] = '{5'd6,  5'd2,  1'b1, 1'b1, 5'd6,  1'b0, 1'b0, O_NORM}; // match, not a load
        tbl[6] = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd3,  1'b0, 1'b1, O_BR};   // branch only
        tbl[7] = '{5'd7,  5'd5,  1'b1, 1'b1, 5'd5,  1'b1, 1'b1, O_BR};   // branch beats load-use
        tbl[8] = '{5'd31, 5'd0,  1'b1, 1'b0, 5'd31, 1'b1, 1'b0, O_LU};   // rd = 31
        tbl[9] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, O_NORM}; // idle

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #2;
            chk_o("reset_out", O_FRZ, 2'd0);
            chk_cnt("reset_cnt", 0, 0);
        end
        @(negedge clk);
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        chk_o("post_reset", O_NORM, 2'd0);

        // Single-cycle RUN vectors.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
                  tbl[i].mr, tbl[i].br, 1'b0, 1'b0);
            #2;
            chk_o($sformatf("vec%0d", i), tbl[i].exp_o, 2'd0);
        end
        step(1'b0, 1'b0, 1'b0);
        chk_cnt("vec_cnt", 3, 2);

        // Single load-use bubble counts once.
        reset_dut();
        drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        chk_o("lu_one", O_LU, 2'd0);
        step(1'b0, 1'b0, 1'b0);
        chk_o("lu_after", O_NORM, 2'd0);
        chk_cnt("lu_cnt", 1, 0);

        // dm_busy for 4 cycles, released the cycle it falls.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk_o($sformatf("mwait%0d", i), O_FRZ, (i == 0) ? 2'd0 : 2'd1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk_o("mwait_release", O_NORM, 2'd1);
        step(1'b0, 1'b0, 1'b0);
        chk_o("mwait_run", O_NORM, 2'd0);
        chk_cnt("mwait_cnt", 4, 0);

        // Redirect during an im_busy freeze, remembered until release.
        reset_dut();
        step(1'b1, 1'b1, 1'b0);
        chk_o("pend_c1", O_FRZ, 2'd0);
        step(1'b0, 1'b1, 1'b0);
        chk_o("pend_c2", O_FRZ, 2'd2);
        step(1'b0, 1'b1, 1'b0);
        chk_o("pend_c3", O_FRZ, 2'd2);
        step(1'b0, 1'b0, 1'b0);
        chk_o("pend_release", O_BR, 2'd2);
        step(1'b0, 1'b0, 1'b0);
        chk_o("pend_run", O_NORM, 2'd0);
        chk_cnt("pend_cnt", 3, 1);

        // Redirect arriving while already in MWAIT.
        reset_dut();
        step(1'b0, 1'b0, 1'b1);
        chk_o("mw_br_c1", O_FRZ, 2'd0);
        step(1'b1, 1'b0, 1'b1);
        chk_o("mw_br_c2", O_FRZ, 2'd1);
        step(1'b0, 1'b0, 1'b0);
        chk_o("mw_br_release", O_BR, 2'd2);
        step(1'b0, 1'b0, 1'b0);
        chk_o("mw_br_run", O_NORM, 2'd0);
        chk_cnt("mw_br_cnt", 2, 1);

        // Reset while a redirect is pending drops it.
        reset_dut();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_o("rst_pend_pre", O_FRZ, 2'd2);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk_o("rst_pend_in", O_FRZ, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk_o("rst_pend_out", O_NORM, 2'd0);
        chk_cnt("rst_pend_cnt", 0, 0);

        // 17 frozen cycles wrap the 4-bit stall counter to 1.
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (i == 16) begin
                chk_o("wrap_last", O_FRZ, 2'd1);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        chk_o("wrap_release", O_NORM, 2'd1);
        step(1'b0, 1'b0, 1'b0);
        chk_cnt("wrap_cnt", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
